// File: rtl/axi2mem_tcdm_synch_fork.sv
// Forks one upstream synch event (with ID) into two independent per-branch queues (0 = read, 1 = write).
// Optional macro AXI2MEM_SYNCH_FORK_BYPASS_EN enables same-cycle fall-through into empty branches.
module axi2mem_tcdm_synch_fork #(
    parameter int ID_WIDTH = 6,
    parameter int DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_en_i,
    input  logic                     synch_req_i,
    input  logic [ID_WIDTH-1:0]      synch_id_i,
    output logic                     synch_gnt_o,
    output logic [1:0]               synch_req_o,
    output logic [1:0][ID_WIDTH-1:0] synch_id_o,
    input  logic [1:0]               synch_gnt_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    // Handshakes: a transfer happens on a cycle where req and gnt are both high.
    // Upstream gnt depends only on req and registered fill state, never on the
    // branch gnts, so a branch popping out of a full queue frees room only for
    // the following cycle. Branch gnt is ignored while that branch's req is low.
    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic       w_push;
    logic       w_unused_test_en;

    assign w_unused_test_en = test_en_i;
    assign w_push           = synch_req_i & ~w_full[0] & ~w_full[1];
    assign synch_gnt_o      = w_push;

    for (genvar g = 0; g < 2; g++) begin : g_branch
        logic [ID_WIDTH-1:0] r_buf [DEPTH];
        logic [PW-1:0]       r_rptr;
        logic [PW-1:0]       r_wptr;
        logic [CW-1:0]       r_cnt;
        logic                w_write;
        logic                w_pop;

        assign w_full[g]  = (r_cnt == CNT_FULL);
        assign w_empty[g] = (r_cnt == '0);

`ifdef AXI2MEM_SYNCH_FORK_BYPASS_EN
        logic w_bypass;
        assign w_bypass       = w_push & w_empty[g];
        assign synch_req_o[g] = ~w_empty[g] | w_bypass;
        assign synch_id_o[g]  = w_bypass ? synch_id_i : r_buf[r_rptr];
        // A bypassed event taken by the consumer right away never enters the queue.
        assign w_write        = w_push & ~(w_bypass & synch_gnt_i[g]);
        assign w_pop          = ~w_empty[g] & synch_gnt_i[g];
`else
        assign synch_req_o[g] = ~w_empty[g];
        assign synch_id_o[g]  = r_buf[r_rptr];
        assign w_write        = w_push;
        assign w_pop          = ~w_empty[g] & synch_gnt_i[g];
`endif

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rptr <= '0;
                r_wptr <= '0;
                r_cnt  <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    r_buf[k] <= '0;
                end
            end else begin
                if (w_write) begin
                    r_buf[r_wptr] <= synch_id_i;
                    r_wptr        <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
                end
                case ({w_write, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi2mem_tcdm_synch_fork.sv
// Directed bench for axi2mem_tcdm_synch_fork: a DEPTH=2 instance for stall/full/reset scenarios
// and a DEPTH=3 instance for continuous-throughput and pointer-wrap ordering.
`timescale 1ns/1ps
module tb_axi2mem_tcdm_synch_fork;

    localparam int IDW = 6;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                d2_req;
    logic [IDW-1:0]      d2_id;
    logic                d2_gnt;
    logic [1:0]          d2_req_o;
    logic [1:0][IDW-1:0] d2_id_o;
    logic [1:0]          d2_gnt_i;

    logic                d3_req;
    logic [IDW-1:0]      d3_id;
    logic                d3_gnt;
    logic [1:0]          d3_req_o;
    logic [1:0][IDW-1:0] d3_id_o;
    logic [1:0]          d3_gnt_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDW-1:0] exp_q0[$];
    logic [IDW-1:0] exp_q1[$];

    axi2mem_tcdm_synch_fork #(.ID_WIDTH(IDW), .DEPTH(2)) u_dut2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_en_i   (1'b0),
        .synch_req_i (d2_req),
        .synch_id_i  (d2_id),
        .synch_gnt_o (d2_gnt),
        .synch_req_o (d2_req_o),
        .synch_id_o  (d2_id_o),
        .synch_gnt_i (d2_gnt_i)
    );

    axi2mem_tcdm_synch_fork #(.ID_WIDTH(IDW), .DEPTH(3)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_en_i   (1'b0),
        .synch_req_i (d3_req),
        .synch_id_i  (d3_id),
        .synch_gnt_o (d3_gnt),
        .synch_req_o (d3_req_o),
        .synch_id_o  (d3_id_o),
        .synch_gnt_i (d3_gnt_i)
    );

    // driver tasks: inputs change 1ns after the rising edge, checks happen at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive2(input logic req, input logic [IDW-1:0] id, input logic [1:0] gnt);
        d2_req   = req;
        d2_id    = id;
        d2_gnt_i = gnt;
    endtask

    task automatic drive3(input logic req, input logic [IDW-1:0] id, input logic [1:0] gnt);
        d3_req   = req;
        d3_id    = id;
        d3_gnt_i = gnt;
    endtask

    task automatic test_reset();
        drive2(1'b0, '0, 2'b00);
        drive3(1'b0, '0, 2'b00);
        #3;
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_o d2: got %b need 00", d2_req_o); end
        n_checks++; if (d2_id_o !== '0) begin n_fail++; $display("FAIL reset_id_o d2: got %h need 0", d2_id_o); end
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt d2: got %b need 0", d2_gnt); end
        n_checks++; if (d3_req_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_o d3: got %b need 00", d3_req_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(); drive2(1'b1, 6'h15, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt c0: got %b need 1", d2_gnt); end
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL single_req c0: got %b need 00", d2_req_o); end
        step(); drive2(1'b0, '0, 2'b11); mid();
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL single_req c1: got %b need 11", d2_req_o); end
        n_checks++; if (d2_id_o !== {6'h15, 6'h15}) begin n_fail++; $display("FAIL single_id c1: got %h need 555", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL single_req c2: got %b need 00", d2_req_o); end
    endtask

    task automatic test_stall();
        step(); drive2(1'b1, 6'd1, 2'b01); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt id1: got %b need 1", d2_gnt); end
        step(); drive2(1'b1, 6'd2, 2'b01); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt id2: got %b need 1", d2_gnt); end
        n_checks++; if (d2_id_o !== {6'd1, 6'd1}) begin n_fail++; $display("FAIL stall_id c1: got %h need {1,1}", d2_id_o); end
        step(); drive2(1'b1, 6'd3, 2'b01); mid();
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt id3 full: got %b need 0", d2_gnt); end
        n_checks++; if (d2_id_o !== {6'd1, 6'd2}) begin n_fail++; $display("FAIL stall_id c2: got %h need {1,2}", d2_id_o); end
        step(); drive2(1'b1, 6'd3, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt full_pop: got %b need 0", d2_gnt); end
        n_checks++; if (d2_req_o !== 2'b10) begin n_fail++; $display("FAIL stall_req c3: got %b need 10", d2_req_o); end
        n_checks++; if (d2_id_o[1] !== 6'd1) begin n_fail++; $display("FAIL stall_id1 c3: got %h need 1", d2_id_o[1]); end
        step(); drive2(1'b1, 6'd3, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt release: got %b need 1", d2_gnt); end
        n_checks++; if (d2_id_o[1] !== 6'd2) begin n_fail++; $display("FAIL stall_id1 c4: got %h need 2", d2_id_o[1]); end
        step(); drive2(1'b0, '0, 2'b11); mid();
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL stall_req c5: got %b need 11", d2_req_o); end
        n_checks++; if (d2_id_o !== {6'd3, 6'd3}) begin n_fail++; $display("FAIL stall_id c5: got %h need {3,3}", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL stall_req c6: got %b need 00", d2_req_o); end
    endtask

    task automatic test_full_pop();
        step(); drive2(1'b1, 6'h11, 2'b00); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt c0: got %b need 1", d2_gnt); end
        step(); drive2(1'b1, 6'h12, 2'b00); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt c1: got %b need 1", d2_gnt); end
        step(); drive2(1'b1, 6'h13, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL full_gnt pop_same_cycle: got %b need 0", d2_gnt); end
        n_checks++; if (d2_id_o !== {6'h11, 6'h11}) begin n_fail++; $display("FAIL full_id c2: got %h need {11,11}", d2_id_o); end
        step(); drive2(1'b1, 6'h13, 2'b00); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL full_gnt next_cycle: got %b need 1", d2_gnt); end
        n_checks++; if (d2_id_o !== {6'h12, 6'h12}) begin n_fail++; $display("FAIL full_id c3: got %h need {12,12}", d2_id_o); end
        step(); drive2(1'b1, 6'h14, 2'b00); mid();
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL full_gnt refull: got %b need 0", d2_gnt); end
        step(); drive2(1'b0, '0, 2'b11); mid();
        n_checks++; if (d2_id_o !== {6'h12, 6'h12}) begin n_fail++; $display("FAIL full_id c5: got %h need {12,12}", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_id_o !== {6'h13, 6'h13}) begin n_fail++; $display("FAIL full_id c6: got %h need {13,13}", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL full_req drained: got %b need 00", d2_req_o); end
    endtask

    task automatic test_throughput();
        int delivered;
        logic [IDW-1:0] exp_id;
        delivered = 0;
        exp_q0.delete();
        exp_q1.delete();
        for (int c = 0; c < 14; c++) begin
            step();
            if (c < 10) drive3(1'b1, IDW'(32 + c), 2'b11);
            else        drive3(1'b0, '0, 2'b11);
            mid();
            if (c < 10) begin
                n_checks++; if (d3_gnt !== 1'b1) begin n_fail++; $display("FAIL thru_gnt c%0d: got %b need 1", c, d3_gnt); end
            end
            if (c >= 1 && c <= 10) begin
                n_checks++; if (d3_req_o !== 2'b11) begin n_fail++; $display("FAIL thru_req c%0d: got %b need 11", c, d3_req_o); end
            end
            if (d3_req_o[0]) begin
                exp_id = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
                n_checks++; if (d3_id_o[0] !== exp_id) begin n_fail++; $display("FAIL thru_id0 c%0d: got %h need %h", c, d3_id_o[0], exp_id); end
                delivered++;
            end
            if (d3_req_o[1]) begin
                exp_id = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
                n_checks++; if (d3_id_o[1] !== exp_id) begin n_fail++; $display("FAIL thru_id1 c%0d: got %h need %h", c, d3_id_o[1], exp_id); end
                delivered++;
            end
            if (d3_gnt) begin
                exp_q0.push_back(d3_id);
                exp_q1.push_back(d3_id);
            end
        end
        n_checks++; if (delivered != 20) begin n_fail++; $display("FAIL thru_count: got %0d need 20", delivered); end
        n_checks++; if (exp_q0.size() + exp_q1.size() != 0) begin n_fail++; $display("FAIL thru_leftover: got %0d need 0", exp_q0.size() + exp_q1.size()); end
        n_checks++; if (d3_req_o !== 2'b00) begin n_fail++; $display("FAIL thru_idle: got %b need 00", d3_req_o); end
    endtask

    task automatic test_reset_midflight();
        step(); drive2(1'b1, 6'h07, 2'b00); mid();
        step(); drive2(1'b1, 6'h08, 2'b00); mid();
        step(); drive2(1'b0, '0, 2'b00); mid();
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre_req: got %b need 11", d2_req_o); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_req: got %b need 00", d2_req_o); end
        n_checks++; if (d2_id_o !== '0) begin n_fail++; $display("FAIL rstmid_id: got %h need 0", d2_id_o); end
        n_checks++; if (d2_gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt: got %b need 0", d2_gnt); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); drive2(1'b1, 6'h3F, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_post_gnt: got %b need 1", d2_gnt); end
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_post_req c0: got %b need 00", d2_req_o); end
        step(); drive2(1'b0, '0, 2'b11); mid();
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL rstmid_post_req c1: got %b need 11", d2_req_o); end
        n_checks++; if (d2_id_o !== {6'h3F, 6'h3F}) begin n_fail++; $display("FAIL rstmid_post_id: got %h need {3f,3f}", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_post_req c2: got %b need 00", d2_req_o); end
    endtask

    task automatic test_bypass();
        step(); drive2(1'b1, 6'h0A, 2'b11); mid();
        n_checks++; if (d2_gnt !== 1'b1) begin n_fail++; $display("FAIL bypass_gnt: got %b need 1", d2_gnt); end
`ifdef AXI2MEM_SYNCH_FORK_BYPASS_EN
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL bypass_req c0: got %b need 11", d2_req_o); end
        n_checks++; if (d2_id_o !== {6'h0A, 6'h0A}) begin n_fail++; $display("FAIL bypass_id c0: got %h need {0a,0a}", d2_id_o); end
        step(); drive2(1'b0, '0, 2'b00); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL bypass_cnt0: got %b need 00", d2_req_o); end
`else
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL nobypass_req c0: got %b need 00", d2_req_o); end
        step(); drive2(1'b0, '0, 2'b11); mid();
        n_checks++; if (d2_req_o !== 2'b11) begin n_fail++; $display("FAIL nobypass_req c1: got %b need 11", d2_req_o); end
        n_checks++; if (d2_id_o !== {6'h0A, 6'h0A}) begin n_fail++; $display("FAIL nobypass_id c1: got %h need {0a,0a}", d2_id_o); end
        step(); mid();
        n_checks++; if (d2_req_o !== 2'b00) begin n_fail++; $display("FAIL nobypass_req c2: got %b need 00", d2_req_o); end
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_full_pop();
        test_throughput();
        test_reset_midflight();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
